// File: rtl/steer_en_ctrl.sv
// Steering-enable controller: rider detect, balance timer, optional battery check.
// Define BATT_CHK_EN to enable the low-battery drop out of STEER.
module steer_en_ctrl #(
  parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
  parameter logic [25:0] TMR_CYCLES   = 26'd67_108_864,
  parameter logic [11:0] BATT_THRESH  = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEER
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] tmr_q, tmr_d;
  logic [12:0] sum;
  logic [11:0] diff;
  logic [16:0] sum15;
  logic        wt_ok;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        batt_chk;

  always_comb begin
    sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff          = (lft_ld >= rght_ld) ? (lft_ld - rght_ld)
                                        : (rght_ld - lft_ld);
    sum15         = {4'b0, sum} * 17'd15;
    wt_ok         = sum > MIN_RIDER_WT;
    diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    diff_gt_15_16 = {1'b0, diff} > sum15[16:4];
  end

`ifdef BATT_CHK_EN
  logic batt_low_q, batt_low_d;

  always_comb begin
    batt_low_d = batt < BATT_THRESH;
  end

  always_ff @(posedge clk) begin
    if (rst) batt_low_q <= 1'b0;
    else     batt_low_q <= batt_low_d;
  end

  assign batt_chk = batt_low_q;
  assign batt_low = batt_low_q;
`else
  // Battery input is kept on the port list but has no effect here.
  logic unused_batt;
  assign unused_batt = ^{batt, BATT_THRESH};
  assign batt_chk    = 1'b0;
  assign batt_low    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (wt_ok) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      WAIT: begin
        if (!wt_ok) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (diff_gt_1_4 || batt_chk) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_CYCLES - 26'd1) begin
          state_d = STEER;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 26'd1;
        end
      end
      STEER: begin
        if (!wt_ok) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (diff_gt_15_16 || batt_chk) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign en_steer  = (state_q == STEER);
  assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl with TMR_CYCLES=8.
// Battery scenario follows BATT_CHK_EN.
module tb_steer_en_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        en_steer, rider_off, batt_low;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  steer_en_ctrl #(
    .MIN_RIDER_WT(13'h200),
    .TMR_CYCLES  (26'd8),
    .BATT_THRESH (12'h800)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .en_steer (en_steer),
    .rider_off(rider_off),
    .batt_low (batt_low)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(12'h000, 12'h000);
    step();
    rst = 1'b0;
  endtask

  task automatic mount_to_steer();
    drive(12'h180, 12'h180);
    repeat (9) step();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    batt = 12'hFFF;
    drive(12'h300, 12'h300);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({en_steer, rider_off, batt_low} !== 3'b010) begin
        n_bad++;
        $display("FAIL reset[%0d] en/off/bl=%b exp=010", i,
                 {en_steer, rider_off, batt_low});
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (rider_off !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release rider_off=%b exp=0", rider_off);
    end
  endtask

  task automatic test_threshold();
    do_rst();
    drive(12'h100, 12'h100);
    repeat (3) step();
    n_cmp++;
    if (rider_off !== 1'b1) begin
      n_bad++;
      $display("FAIL thresh_eq rider_off=%b exp=1", rider_off);
    end
    drive(12'h100, 12'h101);
    step();
    n_cmp++;
    if (rider_off !== 1'b0) begin
      n_bad++;
      $display("FAIL thresh_gt rider_off=%b exp=0", rider_off);
    end
  endtask

  task automatic test_mount();
    int n;
    n = 99;
    do_rst();
    drive(12'h180, 12'h180);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) begin
        n_cmp++;
        if ({en_steer, rider_off} !== 2'b00) begin
          n_bad++;
          $display("FAIL mount_wait en/off=%b exp=00",
                   {en_steer, rider_off});
        end
      end
      if (en_steer === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != 9) begin
      n_bad++;
      $display("FAIL mount_latency edges=%0d exp=9", n);
    end
  endtask

  task automatic test_wait_imbalance();
    int n;
    n = 99;
    do_rst();
    drive(12'h180, 12'h180);
    repeat (6) step();
    drive(12'h300, 12'h080);
    step();
    drive(12'h180, 12'h180);
    for (int i = 2; i <= 20; i++) begin
      step();
      if (en_steer === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != 9) begin
      n_bad++;
      $display("FAIL wait_imb_relatch edges=%0d exp=9", n);
    end
  endtask

  task automatic test_steer_exit();
    drive(12'h340, 12'h020);
    repeat (2) step();
    n_cmp++;
    if (en_steer !== 1'b1) begin
      n_bad++;
      $display("FAIL steer_hold en_steer=%b exp=1", en_steer);
    end
    drive(12'h350, 12'h010);
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b00) begin
      n_bad++;
      $display("FAIL steer_exit en/off=%b exp=00", {en_steer, rider_off});
    end
  endtask

  task automatic test_dismount();
    do_rst();
    mount_to_steer();
    n_cmp++;
    if (en_steer !== 1'b1) begin
      n_bad++;
      $display("FAIL dism_pre en_steer=%b exp=1", en_steer);
    end
    drive(12'h0FF, 12'h0FF);
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b01) begin
      n_bad++;
      $display("FAIL dismount en/off=%b exp=01", {en_steer, rider_off});
    end
    mount_to_steer();
    drive(12'h1F0, 12'h000);
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b01) begin
      n_bad++;
      $display("FAIL dism_imb en/off=%b exp=01", {en_steer, rider_off});
    end
  endtask

  task automatic test_reset_mid();
    do_rst();
    drive(12'h180, 12'h180);
    repeat (5) step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_wait en/off=%b exp=01", {en_steer, rider_off});
    end
    rst = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (en_steer !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_recount en_steer=%b exp=0", en_steer);
    end
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_steer en/off=%b exp=01", {en_steer, rider_off});
    end
    rst = 1'b0;
  endtask

  task automatic test_batt();
    int n;
    n = 99;
    do_rst();
    batt = 12'hFFF;
    mount_to_steer();
    batt = 12'h7FF;
    step();
`ifdef BATT_CHK_EN
    n_cmp++;
    if ({batt_low, en_steer} !== 2'b11) begin
      n_bad++;
      $display("FAIL batt_flag bl/en=%b exp=11", {batt_low, en_steer});
    end
    step();
    n_cmp++;
    if ({en_steer, rider_off} !== 2'b00) begin
      n_bad++;
      $display("FAIL batt_exit en/off=%b exp=00", {en_steer, rider_off});
    end
    repeat (4) step();
    batt = 12'h800;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) begin
        n_cmp++;
        if (batt_low !== 1'b0) begin
          n_bad++;
          $display("FAIL batt_clear batt_low=%b exp=0", batt_low);
        end
      end
      if (en_steer === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != 9) begin
      n_bad++;
      $display("FAIL batt_reenable edges=%0d exp=9", n);
    end
`else
    repeat (2) step();
    n_cmp++;
    if ({batt_low, en_steer} !== 2'b01) begin
      n_bad++;
      $display("FAIL batt_ignored bl/en=%b exp=01", {batt_low, en_steer});
    end
`endif
  endtask

  initial begin
    rst  = 1'b1;
    batt = 12'hFFF;
    drive(12'h000, 12'h000);
    test_reset();
    test_threshold();
    test_mount();
    test_wait_imbalance();
    test_steer_exit();
    test_dismount();
    test_reset_mid();
    test_batt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
